uart_tx_frame: RTL and testbench

- Serial transmitter closing the loop behind the RX processing stage: accepts single-cycle byte strobes (tx_data/tx_en style) and serializes them onto the UART line as 8N1 frames, LSB first.
- One-byte holding register decouples the strobing producer from the bit-serial shifter, so a byte can arrive while the previous frame is still on the wire.
- Sits between the byte-processing stage and the board TX pin.

---
 rtl/uart_tx_frame.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - 8N1 UART transmitter with one-byte holding register
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       tx_pin
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CYCLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      bit_next;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic            pin_q, pin_d;
  logic            ovf_q, ovf_d;
  logic            baud_end;

  assign baud_end = (baud_q == BAUD_LAST);
  assign bit_next = bit_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    pin_d        = pin_q;
    ovf_d        = tx_en & hold_valid_q;

    // Accept and drain are mutually exclusive: both key off the registered hold_valid.
    if (tx_en && !hold_valid_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        pin_d  = 1'b1;
        baud_d = '0;
        if (hold_valid_q) begin
          state_d      = START;
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          pin_d        = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          pin_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            pin_d   = ^shift_q;
`else
            state_d = STOP;
            pin_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_next;
            pin_d = shift_q[bit_next];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
          baud_d  = '0;
          pin_d   = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // A waiting byte goes straight into its start bit with no idle gap.
          if (hold_valid_q) begin
            state_d      = START;
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            pin_d        = 1'b0;
          end else begin
            state_d = IDLE;
            pin_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        pin_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      pin_q        <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      pin_q        <= pin_d;
      ovf_q        <= ovf_d;
    end
  end

  assign tx_ready    = ~hold_valid_q;
  assign tx_busy     = (state_q != IDLE);
  assign tx_overflow = ovf_q;
  assign tx_pin      = pin_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame
// Line decoder pops expected bytes; define UART_TX_PARITY_EN to cover the parity build.
module tb_uart_tx_frame;

  localparam int CYCLE = 50 * 1000000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CYCLE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_en = 1'b0;
  logic       tx_ready, tx_busy, tx_overflow, tx_pin;

  uart_tx_frame dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_en(tx_en),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_overflow(tx_overflow), .tx_pin(tx_pin)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]    exp_q[$];
  logic [NB-1:0] mon_bits, last_bits;
  bit            mon_active = 1'b0;
  logic          prev_pin = 1'b1;
  int            mon_cnt = 0;
  int            frames_seen = 0;
  int            busy_run = 0, last_run = 0, busy_rises = 0, ovf_cnt = 0;
  logic          prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: decode each frame at bit centres and compare against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
      prev_pin   = 1'b1;
    end else if (!mon_active) begin
      if (prev_pin && !tx_pin) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_bits   = '0;
      end
      prev_pin = tx_pin;
    end else begin
      mon_cnt++;
    end
    if (!reset && mon_active && (mon_cnt % CYCLE) == CYCLE / 2) begin
      mon_bits[mon_cnt / CYCLE] = tx_pin;
      if (mon_cnt / CYCLE == NB - 1) begin
        logic [7:0] e;
        last_bits = mon_bits;
        frames_seen++;
        check("start_bit", {31'd0, mon_bits[0]}, 32'd0);
        check("stop_bit", {31'd0, mon_bits[NB-1]}, 32'd1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got %0h, expected no frame", mon_bits[8:1]);
        end else begin
          e = exp_q.pop_front();
          check("data_byte", {24'd0, mon_bits[8:1]}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
          check("parity_bit", {31'd0, mon_bits[9]}, {31'd0, ^e});
`endif
        end
        mon_active = 1'b0;
        prev_pin   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_overflow) ovf_cnt++;
    if (tx_busy && !prev_busy) busy_rises++;
    if (tx_busy) busy_run++;
    else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
    end
    prev_busy = tx_busy;
  end

  task automatic strobe(input logic [7:0] b, input bit accept);
    @(posedge clk); #1;
    check("ready_at_strobe", {31'd0, tx_ready}, {31'd0, accept});
    tx_en   = 1'b1;
    tx_data = b;
    if (accept) exp_q.push_back(b);
    @(posedge clk); #1;
    tx_en   = 1'b0;
    tx_data = 8'hC6;
    check("overflow_after_strobe", {31'd0, tx_overflow}, {31'd0, !accept});
    if (!accept) begin
      @(posedge clk); #1;
      check("overflow_one_cycle", {31'd0, tx_overflow}, 32'd0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk);
    while ((tx_busy || mon_active) && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, n < 3 * FRAME}, 32'd1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int rises0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_state", {28'd0, tx_pin, tx_ready, tx_busy, tx_overflow}, 32'hC);
    reset = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("idle_outputs", {28'd0, tx_pin, tx_ready, tx_busy, tx_overflow}, 32'hC);
    end

    strobe(8'h55, 1'b1);
    check("pin_before_start", {31'd0, tx_pin}, 32'd1);
    check("ready_while_held", {31'd0, tx_ready}, 32'd0);
    @(posedge clk); #1;
    check("start_one_clk", {30'd0, tx_pin, tx_busy}, 32'h1);
    wait_idle();
    check("frame_len_55", last_run, FRAME);
`ifdef UART_TX_PARITY_EN
    check("bits_55", {21'd0, last_bits}, 32'b10010101010);
`else
    check("bits_55", {22'd0, last_bits}, 32'b1010101010);
`endif

    strobe(8'hA3, 1'b1);
    repeat (10) @(posedge clk);
    strobe(8'h0F, 1'b1);
    wait_idle();
    check("back_to_back_len", last_run, 2 * FRAME);
    check("no_overflow_b2b", ovf_cnt, 0);

    strobe(8'h11, 1'b1);
    repeat (10) @(posedge clk);
    strobe(8'h22, 1'b1);
    repeat (10) @(posedge clk);
    strobe(8'h33, 1'b0);
    wait_idle();
    check("overflow_count", ovf_cnt, 1);

    strobe(8'hFF, 1'b1);
    repeat (10) @(posedge clk);
    strobe(8'h5A, 1'b1);
    repeat (1985) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("abort_outputs", {28'd0, tx_pin, tx_ready, tx_busy, tx_overflow}, 32'hC);
    reset = 1'b0;
    rises0 = busy_rises;
    repeat (5000) @(posedge clk);
    check("no_frame_after_abort", busy_rises, rises0);
    strobe(8'h42, 1'b1);
    wait_idle();
    check("frame_len_42", last_run, FRAME);

`ifdef UART_TX_PARITY_EN
    strobe(8'h07, 1'b1);
    wait_idle();
    check("frame_len_07", last_run, 4774);
    check("parity_07", {31'd0, last_bits[9]}, 32'd1);
    strobe(8'h03, 1'b1);
    wait_idle();
    check("parity_03", {31'd0, last_bits[9]}, 32'd0);
    check("frames_seen", frames_seen, 8);
`else
    check("frames_seen", frames_seen, 6);
`endif
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
